// File: rtl/flush_sequencer.sv
// Fence flush sequencer: orders dcache writeback, icache invalidate, bus quiesce,
// timing pad and uarch reset. FENCE completes 3 cycles after request plus ack delay.
// Requests arriving mid-sequence are latched and serviced afterwards; core is halted meanwhile.
module flush_sequencer #(
  parameter int RST_CYCLES = 16,
  parameter int PAD_WIDTH  = 32,
  parameter int VLEN       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fence_req_i,
  input  logic                 fence_i_req_i,
  input  logic                 fence_t_req_i,
  input  logic [VLEN-1:0]      pc_commit_i,
  output logic                 flush_dcache_o,
  input  logic                 flush_dcache_ack_i,
  output logic                 flush_icache_o,
  input  logic                 cache_busy_i,
  input  logic                 time_irq_i,
  input  logic [PAD_WIDTH-1:0] fence_t_pad_i,
  output logic                 rst_uarch_no,
  output logic                 cache_init_no,
  output logic [VLEN-1:0]      rst_addr_o,
  output logic                 halt_o,
  output logic                 done_o
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH_D, S_FLUSH_I, S_WAIT, S_RST, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  // Pending bits and the snapshot being serviced, ordered {T, I, D}
  logic [2:0]             r_pend;
  logic [2:0]             r_svc;
  logic [2:0]             w_req;
  logic [2:0]             w_clr;
  logic [CW-1:0]          r_rst_cnt;
  logic [CW-1:0]          w_rst_cnt_nxt;
  logic [PAD_WIDTH-1:0]   r_pad_cnt;
  logic                   r_time_irq_q;
  logic                   w_irq_rise;
  logic [2:0]             r_init_sr;
  logic                   r_flush_d;
  logic                   r_flush_i;
  logic                   r_done;
  logic                   r_rst_uarch_n;
  logic [VLEN-1:0]        r_rst_addr;
  logic                   w_need_icache;
  logic                   w_need_fence_t;

  assign w_req          = {fence_t_req_i, fence_i_req_i, fence_req_i};
  // Only the bits snapshotted at sequence start are retired; later arrivals stay pending
  assign w_clr          = (r_state == S_DONE) ? r_svc : 3'b000;
  // FENCE.T implies the icache step; FENCE.I implies the dcache step (always taken)
  assign w_need_icache  = r_svc[1] | r_svc[2];
  assign w_need_fence_t = r_svc[2];
  assign w_irq_rise     = time_irq_i & ~r_time_irq_q;

  // Next-state and reset-counter logic for the sequence FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    unique case (r_state)
      S_IDLE:    if (|r_pend) w_state_nxt = S_FLUSH_D;
      S_FLUSH_D: if (flush_dcache_ack_i) w_state_nxt = w_need_icache ? S_FLUSH_I : S_DONE;
      S_FLUSH_I: w_state_nxt = w_need_fence_t ? S_WAIT : S_DONE;
      S_WAIT:    if (!cache_busy_i && (r_pad_cnt == '0)) w_state_nxt = S_RST;
      S_RST: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt   = S_DONE;
          w_rst_cnt_nxt = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + CW'(1);
        end
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register, registered outputs derived from next state, pending/service bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_rst_cnt     <= '0;
      r_pend        <= 3'b000;
      r_svc         <= 3'b000;
      r_flush_d     <= 1'b0;
      r_flush_i     <= 1'b0;
      r_done        <= 1'b0;
      r_rst_uarch_n <= 1'b1;
      r_init_sr     <= 3'b000;
    end else begin
      r_state       <= w_state_nxt;
      r_rst_cnt     <= w_rst_cnt_nxt;
      r_pend        <= (r_pend & ~w_clr) | w_req;
      if (r_state == S_IDLE && (|r_pend)) r_svc <= r_pend;
      r_flush_d     <= (w_state_nxt == S_FLUSH_D);
      r_flush_i     <= (w_state_nxt == S_FLUSH_I);
      r_done        <= (w_state_nxt == S_DONE);
      r_rst_uarch_n <= (w_state_nxt != S_RST);
      r_init_sr     <= {r_init_sr[1:0], (r_state == S_RST)};
    end
  end

  // Pad counter: reload on timer-irq rising edge (load beats decrement), else count down to 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_time_irq_q <= 1'b0;
      r_pad_cnt    <= '0;
    end else begin
      r_time_irq_q <= time_irq_i;
      if (w_irq_rise)
        r_pad_cnt <= fence_t_pad_i;
      else if (r_pad_cnt != '0)
        r_pad_cnt <= r_pad_cnt - PAD_WIDTH'(1);
    end
  end

  // Resume address: instruction after the committing FENCE.T
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_rst_addr <= '0;
    else if (fence_t_req_i)
      r_rst_addr <= pc_commit_i + VLEN'(4);
  end

  assign flush_dcache_o = r_flush_d;
  assign flush_icache_o = r_flush_i;
  assign done_o         = r_done;
  assign rst_uarch_no   = r_rst_uarch_n;
  assign cache_init_no  = |r_init_sr;
  assign rst_addr_o     = r_rst_addr;
  assign halt_o         = (r_state != S_IDLE) | (|r_pend);

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer: vector table for FENCE/FENCE.I flows,
// hand-written sequences for FENCE.T, merging, wrap and mid-sequence reset.
module tb_flush_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fence_req_i, fence_i_req_i, fence_t_req_i;
  logic [31:0] pc_commit_i;
  logic        flush_dcache_o, flush_dcache_ack_i, flush_icache_o;
  logic        cache_busy_i, time_irq_i;
  logic [31:0] fence_t_pad_i;
  logic        rst_uarch_no, cache_init_no;
  logic [31:0] rst_addr_o;
  logic        halt_o, done_o;

  int n_chk  = 0;
  int n_pass = 0;

  flush_sequencer #(.RST_CYCLES(16), .PAD_WIDTH(32), .VLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fence_req_i(fence_req_i), .fence_i_req_i(fence_i_req_i), .fence_t_req_i(fence_t_req_i),
    .pc_commit_i(pc_commit_i),
    .flush_dcache_o(flush_dcache_o), .flush_dcache_ack_i(flush_dcache_ack_i),
    .flush_icache_o(flush_icache_o),
    .cache_busy_i(cache_busy_i), .time_irq_i(time_irq_i), .fence_t_pad_i(fence_t_pad_i),
    .rst_uarch_no(rst_uarch_no), .cache_init_no(cache_init_no),
    .rst_addr_o(rst_addr_o), .halt_o(halt_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // One vector: inputs for a cycle, then {flush_d, flush_i, done, halt} after the edge
  typedef struct {
    logic       fr;
    logic       fir;
    logic       ack;
    logic [3:0] exp;
  } vec_t;

  vec_t vt[20];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic clear_inputs();
    fence_req_i = 0; fence_i_req_i = 0; fence_t_req_i = 0;
    flush_dcache_ack_i = 0; cache_busy_i = 0; time_irq_i = 0;
  endtask

  // Full FENCE.T run; optional FENCE+FENCE.I merge injected at cycle 20
  task automatic run_t(input string tag, input logic [31:0] pc, input logic [31:0] pad,
                       input int irq_cyc, input int busy_lo, input int busy_hi, input bit merge,
                       input logic [31:0] exp_addr, input int exp_first_rst,
                       input int exp_done1, input int exp_done2);
    int first_rst = -1, low_cnt = 0, init_cnt = 0, done_cnt = 0;
    int done1 = -1, done2 = -1, icache_cnt = 0, last_done = -1, exp_n;
    bit halt_gap = 0;
    logic halt_after = 1'b1;
    logic [31:0] addr_c1 = '0;
    exp_n = merge ? 2 : 1;
    pc_commit_i   = pc;
    fence_t_pad_i = pad;
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (cyc >= 1) begin
        if (cyc == 1) addr_c1 = rst_addr_o;
        if (!rst_uarch_no) begin
          low_cnt++;
          if (first_rst < 0) first_rst = cyc;
        end
        if (rst_uarch_no && cache_init_no) init_cnt++;
        if (flush_icache_o) icache_cnt++;
        if (done_cnt < exp_n && !halt_o) halt_gap = 1;
        if (done_o) begin
          done_cnt++;
          if (done_cnt == 1) done1 = cyc; else done2 = cyc;
          last_done = cyc;
        end
        if (last_done >= 0 && cyc == last_done + 1) halt_after = halt_o;
        if (done_cnt == exp_n && cyc == last_done + 4) break;
      end
      fence_t_req_i      = (cyc == 0);
      time_irq_i         = (irq_cyc >= 0 && cyc >= irq_cyc);
      cache_busy_i       = (cyc >= busy_lo && cyc <= busy_hi);
      flush_dcache_ack_i = flush_dcache_o;
      fence_req_i        = merge && (cyc == 20);
      fence_i_req_i      = merge && (cyc == 20);
      step();
    end
    clear_inputs();
    chk({tag, " rst_addr_captured"}, addr_c1, exp_addr);
    chk({tag, " rst_addr_held"}, rst_addr_o, exp_addr);
    chk({tag, " first_rst_cycle"}, first_rst, exp_first_rst);
    chk({tag, " rst_low_cycles"}, low_cnt, 16);
    chk({tag, " cache_init_cycles"}, init_cnt, 3);
    chk({tag, " done_pulses"}, done_cnt, exp_n);
    chk({tag, " done1_cycle"}, done1, exp_done1);
    if (merge) chk({tag, " done2_cycle"}, done2, exp_done2);
    chk({tag, " icache_pulses"}, icache_cnt, exp_n);
    chk({tag, " halt_gap"}, halt_gap, 0);
    chk({tag, " halt_after_done"}, halt_after, 0);
  endtask

  initial begin
    clear_inputs();
    pc_commit_i = '0; fence_t_pad_i = '0;
    rst_i = 1;
    step(); step();
    rst_i = 0;
    chk("reset_outputs", {flush_dcache_o, flush_icache_o, done_o, halt_o, rst_uarch_no, cache_init_no}, 6'b000010);
    chk("reset_rst_addr", rst_addr_o, 32'h0);

    // FENCE with ack 5 cycles after flush rise, FENCE.I with same-cycle ack,
    // stray ack while idle, simultaneous FENCE+FENCE.I merged into one FENCE.I
    vt[0]  = '{1'b1, 1'b0, 1'b0, 4'b0001};
    for (int i = 1; i <= 6; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 4'b1001};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 4'b0011};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 4'b0001};
    vt[10] = '{1'b0, 1'b0, 1'b0, 4'b1001};
    vt[11] = '{1'b0, 1'b0, 1'b1, 4'b0101};
    vt[12] = '{1'b0, 1'b0, 1'b0, 4'b0011};
    vt[13] = '{1'b0, 1'b0, 1'b0, 4'b0000};
    vt[14] = '{1'b0, 1'b0, 1'b1, 4'b0000};
    vt[15] = '{1'b1, 1'b1, 1'b0, 4'b0001};
    vt[16] = '{1'b0, 1'b0, 1'b0, 4'b1001};
    vt[17] = '{1'b0, 1'b0, 1'b1, 4'b0101};
    vt[18] = '{1'b0, 1'b0, 1'b0, 4'b0011};
    vt[19] = '{1'b0, 1'b0, 1'b0, 4'b0000};
    for (int i = 0; i < 20; i++) begin
      fence_req_i        = vt[i].fr;
      fence_i_req_i      = vt[i].fir;
      flush_dcache_ack_i = vt[i].ack;
      step();
      chk($sformatf("vec%0d {fd,fi,done,halt}", i),
          {flush_dcache_o, flush_icache_o, done_o, halt_o}, vt[i].exp);
    end
    clear_inputs();
    step();

    // FENCE.T: pad 10 loaded while in FLUSH_D dominates a 4-cycle busy; merge during RST
    run_t("fence_t_pad", 32'h8000_0FFC, 32'd10, 2, 4, 7, 1'b1, 32'h8000_1000, 14, 30, 34);
    step();

    // Reset in the middle of FLUSH_D, then a stray ack
    fence_req_i = 1; step(); fence_req_i = 0; step();
    chk("pre_reset_flush_d", flush_dcache_o, 1'b1);
    rst_i = 1; step(); rst_i = 0;
    chk("midreset_outputs", {flush_dcache_o, flush_icache_o, done_o, halt_o, rst_uarch_no, cache_init_no}, 6'b000010);
    chk("midreset_rst_addr", rst_addr_o, 32'h0);
    flush_dcache_ack_i = 1; step(); flush_dcache_ack_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stray_ack%0d {fd,done,halt}", i), {flush_dcache_o, done_o, halt_o}, 3'b000);
      step();
    end

    // FENCE.T with all-ones PC (wrap) and busy-only wait
    run_t("fence_t_wrap", 32'hFFFF_FFFF, 32'd0, -1, 4, 7, 1'b0, 32'h0000_0003, 9, 25, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
